// File: rtl/pipeline_pkg.sv
// Shared types and constants for the RV32I pipeline hazard/sequencing controller.
package pipeline_pkg;

    localparam int unsigned CNT_W_DEFAULT = 32;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // Stage-register control bundle driven by the controller.
    // Field order is fixed so the packed constants below stay readable.
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_flush;
    } stage_ctrl_t;

    // Control fields a flushed stage register loads: every field cleared,
    // so the bubble can neither write memory nor the register file.
    localparam logic [15:0] BUBBLE_CTRL = 16'h0000;

    localparam stage_ctrl_t CTRL_RUN   = 8'b1111_1000;
    localparam stage_ctrl_t CTRL_RESET = 8'b0111_1111;
    localparam stage_ctrl_t CTRL_MST   = 8'b0000_1001;
    localparam stage_ctrl_t CTRL_REDIR = 8'b1111_1110;
    localparam stage_ctrl_t CTRL_LUH   = 8'b0011_1010;

    // 16-bit increment that holds at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pipeline_controller_if.sv
// Hazard inputs from the datapath and stage-register controls back to it.
// master: the controller side; slave: the pipeline datapath side.
interface pipeline_controller_if;
    logic [4:0] rs1_id;
    logic [4:0] rs2_id;
    logic       rs1_used_id;
    logic       rs2_used_id;
    logic [4:0] rd_ex;
    logic       load_ex;
    logic       redirect_ex;
    logic       dmem_req_mem;
    logic       dmem_ready;

    logic       pc_en;
    logic       if_id_en;
    logic       id_ex_en;
    logic       ex_mem_en;
    logic       mem_wb_en;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       mem_wb_flush;

    modport master (
        input  rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_ex, load_ex,
               redirect_ex, dmem_req_mem, dmem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, mem_wb_flush
    );

    modport slave (
        output rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_ex, load_ex,
               redirect_ex, dmem_req_mem, dmem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, mem_wb_flush
    );
endinterface

// File: rtl/hazard_detect.sv
// Pure combinational hazard terms: load-use (luh) and data-memory stall (mst).
module hazard_detect (
    input  logic [4:0] rs1_id,
    input  logic [4:0] rs2_id,
    input  logic       rs1_used_id,
    input  logic       rs2_used_id,
    input  logic [4:0] rd_ex,
    input  logic       load_ex,
    input  logic       dmem_req_mem,
    input  logic       dmem_ready,
    output logic       luh,
    output logic       mst
);

    // x0 is never a real destination, so a load to x0 cannot create a hazard.
    always_comb begin
        luh = load_ex && (rd_ex != 5'd0) &&
              ((rs1_used_id && (rs1_id == rd_ex)) ||
               (rs2_used_id && (rs2_id == rd_ex)));
        mst = dmem_req_mem && !dmem_ready;
    end

endmodule

// File: rtl/pipeline_controller.sv
// Hazard/sequencing controller: priority mux for stage enables and flushes,
// MEM wait-state FSM with timeout flag, and performance counters.
module pipeline_controller
    import pipeline_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_controller_if.master bus,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_events,
    output logic [CNT_W-1:0]      mem_wait_cycles,
    output logic                  mem_timeout,
    output logic                  mem_wait_state
);

    localparam logic [15:0] TIMEOUT_LIM = 16'(MEM_TIMEOUT);

    logic        luh;
    logic        mst;
    stage_ctrl_t ctrl;
    logic        redirect_applied;
    mem_state_t  state;
    mem_state_t  state_n;
    logic [15:0] wait_cnt;
    logic [15:0] wait_cnt_inc;

    hazard_detect u_hazard_detect (
        .rs1_id       (bus.rs1_id),
        .rs2_id       (bus.rs2_id),
        .rs1_used_id  (bus.rs1_used_id),
        .rs2_used_id  (bus.rs2_used_id),
        .rd_ex        (bus.rd_ex),
        .load_ex      (bus.load_ex),
        .dmem_req_mem (bus.dmem_req_mem),
        .dmem_ready   (bus.dmem_ready),
        .luh          (luh),
        .mst          (mst)
    );

    // Priority mux: reset, then MEM stall, then redirect, then load-use.
    // A redirect seen during a MEM stall is not lost: EX is frozen, so it is
    // presented again and applied in the first cycle the stall clears.
    always_comb begin
        ctrl             = CTRL_RUN;
        redirect_applied = 1'b0;
        if (rst) begin
            ctrl = CTRL_RESET;
        end else if (mst) begin
            ctrl = CTRL_MST;
        end else if (bus.redirect_ex) begin
            ctrl             = CTRL_REDIR;
            redirect_applied = 1'b1;
        end else if (luh) begin
            ctrl = CTRL_LUH;
        end
    end

    assign bus.pc_en        = ctrl.pc_en;
    assign bus.if_id_en     = ctrl.if_id_en;
    assign bus.id_ex_en     = ctrl.id_ex_en;
    assign bus.ex_mem_en    = ctrl.ex_mem_en;
    assign bus.mem_wb_en    = ctrl.mem_wb_en;
    assign bus.if_id_flush  = ctrl.if_id_flush;
    assign bus.id_ex_flush  = ctrl.id_ex_flush;
    assign bus.mem_wb_flush = ctrl.mem_wb_flush;

    // Wait-state FSM register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic: WAIT tracks an outstanding data-memory access.
    always_comb begin
        state_n = state;
        case (state)
            RUN:     if (mst)  state_n = WAIT;
            WAIT:    if (!mst) state_n = RUN;
            default: state_n = RUN;
        endcase
    end

    assign mem_wait_state = (state == WAIT);
    assign wait_cnt_inc   = sat_inc16(wait_cnt);

    // Wait counter and sticky timeout; the pipeline keeps stalling after timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt    <= 16'd0;
            mem_timeout <= 1'b0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt_inc;
            if (wait_cnt_inc >= TIMEOUT_LIM) begin
                mem_timeout <= 1'b1;
            end
        end else if (state_n == WAIT) begin
            wait_cnt <= 16'd0;
        end
    end

    // Performance counters, free-running modulo 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles    <= '0;
            flush_events    <= '0;
            mem_wait_cycles <= '0;
        end else begin
            if (!ctrl.pc_en)      stall_cycles    <= stall_cycles + CNT_W'(1);
            if (redirect_applied) flush_events    <= flush_events + CNT_W'(1);
            if (mst)              mem_wait_cycles <= mem_wait_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller with MEM_TIMEOUT = 4.
module tb_pipeline_controller;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] stall_cycles, flush_events, mem_wait_cycles;
    logic        mem_timeout, mem_wait_state;
    logic [7:0]  ctl;
    int          n_cmp = 0;
    int          n_bad = 0;

    localparam logic [7:0] E_RUN   = 8'b1111_1000;
    localparam logic [7:0] E_RESET = 8'b0111_1111;
    localparam logic [7:0] E_MST   = 8'b0000_1001;
    localparam logic [7:0] E_REDIR = 8'b1111_1110;
    localparam logic [7:0] E_LUH   = 8'b0011_1010;

    pipeline_controller_if bus_if ();

    pipeline_controller #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus_if),
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events),
        .mem_wait_cycles (mem_wait_cycles),
        .mem_timeout     (mem_timeout),
        .mem_wait_state  (mem_wait_state)
    );

    always #5 clk = ~clk;

    assign ctl = {bus_if.pc_en, bus_if.if_id_en, bus_if.id_ex_en, bus_if.ex_mem_en,
                  bus_if.mem_wb_en, bus_if.if_id_flush, bus_if.id_ex_flush, bus_if.mem_wb_flush};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required < 200000", $time);
        $fatal(1);
    end

    task automatic drive(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic ld,
                         input logic redir, input logic req, input logic rdy);
        bus_if.rs1_id       = rs1;
        bus_if.rs1_used_id  = u1;
        bus_if.rs2_id       = rs2;
        bus_if.rs2_used_id  = u2;
        bus_if.rd_ex        = rd;
        bus_if.load_ex      = ld;
        bus_if.redirect_ex  = redir;
        bus_if.dmem_req_mem = req;
        bus_if.dmem_ready   = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (ctl !== E_RESET) begin n_bad++; $display("FAIL reset_ctl: got %b want %b", ctl, E_RESET); end
        tick();
        n_cmp++;
        if ({stall_cycles, flush_events, mem_wait_cycles} !== 96'd0) begin
            n_bad++; $display("FAIL reset_cnt: got %0d/%0d/%0d want 0/0/0", stall_cycles, flush_events, mem_wait_cycles);
        end
        n_cmp++;
        if ({mem_timeout, mem_wait_state} !== 2'b00) begin
            n_bad++; $display("FAIL reset_flags: got %b%b want 00", mem_timeout, mem_wait_state);
        end
        rst = 1'b0;
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (ctl !== E_RUN) begin n_bad++; $display("FAIL idle_ctl: got %b want %b", ctl, E_RUN); end
        tick();
    endtask

    task automatic test_load_use();
        drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (ctl !== E_LUH) begin n_bad++; $display("FAIL luh_rs1_ctl: got %b want %b", ctl, E_LUH); end
        tick();
        drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (ctl !== E_RUN) begin n_bad++; $display("FAIL luh_after_ctl: got %b want %b", ctl, E_RUN); end
        n_cmp++;
        if (stall_cycles !== 32'd1) begin n_bad++; $display("FAIL luh_stall_cnt: got %0d want 1", stall_cycles); end
        tick();
        drive(5'd1, 1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (ctl !== E_LUH) begin n_bad++; $display("FAIL luh_rs2_ctl: got %b want %b", ctl, E_LUH); end
        tick();
        drive(5'd9, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (ctl !== E_RUN) begin n_bad++; $display("FAIL luh_unused_ctl: got %b want %b", ctl, E_RUN); end
        tick();
        n_cmp++;
        if (stall_cycles !== 32'd2) begin n_bad++; $display("FAIL luh_stall_cnt2: got %0d want 2", stall_cycles); end
    endtask

    task automatic test_rd_zero();
        drive(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (ctl !== E_RUN) begin n_bad++; $display("FAIL rd_zero_ctl: got %b want %b", ctl, E_RUN); end
        tick();
        n_cmp++;
        if (stall_cycles !== 32'd2) begin n_bad++; $display("FAIL rd_zero_stall_cnt: got %0d want 2", stall_cycles); end
    endtask

    task automatic test_redirect_luh();
        drive(5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (ctl !== E_REDIR) begin n_bad++; $display("FAIL redir_ctl: got %b want %b", ctl, E_REDIR); end
        tick();
        n_cmp++;
        if (flush_events !== 32'd1) begin n_bad++; $display("FAIL redir_flush_cnt: got %0d want 1", flush_events); end
        n_cmp++;
        if (stall_cycles !== 32'd2) begin n_bad++; $display("FAIL redir_stall_cnt: got %0d want 2", stall_cycles); end
    endtask

    task automatic test_mem_stall();
        for (int k = 1; k <= 3; k++) begin
            drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            n_cmp++;
            if (ctl !== E_MST) begin n_bad++; $display("FAIL mst_ctl[%0d]: got %b want %b", k, ctl, E_MST); end
            n_cmp++;
            if (mem_wait_state !== (k > 1)) begin
                n_bad++; $display("FAIL mst_state[%0d]: got %b want %b", k, mem_wait_state, (k > 1));
            end
            tick();
        end
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (ctl !== E_RUN) begin n_bad++; $display("FAIL mst_done_ctl: got %b want %b", ctl, E_RUN); end
        n_cmp++;
        if (mem_wait_state !== 1'b1) begin n_bad++; $display("FAIL mst_state_last: got %b want 1", mem_wait_state); end
        tick();
        n_cmp++;
        if (mem_wait_state !== 1'b0) begin n_bad++; $display("FAIL mst_state_exit: got %b want 0", mem_wait_state); end
        n_cmp++;
        if (mem_wait_cycles !== 32'd3) begin n_bad++; $display("FAIL mst_wait_cnt: got %0d want 3", mem_wait_cycles); end
        n_cmp++;
        if (stall_cycles !== 32'd5) begin n_bad++; $display("FAIL mst_stall_cnt: got %0d want 5", stall_cycles); end
    endtask

    task automatic test_redirect_during_stall();
        for (int k = 1; k <= 2; k++) begin
            drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
            n_cmp++;
            if (ctl !== E_MST) begin n_bad++; $display("FAIL held_redir_ctl[%0d]: got %b want %b", k, ctl, E_MST); end
            tick();
        end
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        n_cmp++;
        if (ctl !== E_REDIR) begin n_bad++; $display("FAIL held_redir_release: got %b want %b", ctl, E_REDIR); end
        tick();
        n_cmp++;
        if (flush_events !== 32'd2) begin n_bad++; $display("FAIL held_redir_flush_cnt: got %0d want 2", flush_events); end
        n_cmp++;
        if ({stall_cycles, mem_wait_cycles} !== {32'd7, 32'd5}) begin
            n_bad++; $display("FAIL held_redir_cnts: got %0d/%0d want 7/5", stall_cycles, mem_wait_cycles);
        end
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_timeout();
        for (int k = 1; k <= 10; k++) begin
            drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
            n_cmp++;
            if (mem_timeout !== (k >= 5)) begin
                n_bad++; $display("FAIL timeout[%0d]: got %b want %b", k, mem_timeout, (k >= 5));
            end
        end
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        n_cmp++;
        if (mem_timeout !== 1'b1) begin n_bad++; $display("FAIL timeout_sticky: got %b want 1", mem_timeout); end
        n_cmp++;
        if ({stall_cycles, mem_wait_cycles} !== {32'd17, 32'd15}) begin
            n_bad++; $display("FAIL timeout_cnts: got %0d/%0d want 17/15", stall_cycles, mem_wait_cycles);
        end
        for (int k = 1; k <= 2; k++) begin
            drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
        end
        n_cmp++;
        if (mem_wait_state !== 1'b1) begin n_bad++; $display("FAIL pre_rst_state: got %b want 1", mem_wait_state); end
        rst = 1'b1;
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (ctl !== E_RESET) begin n_bad++; $display("FAIL rst_in_wait_ctl: got %b want %b", ctl, E_RESET); end
        tick();
        n_cmp++;
        if ({mem_timeout, mem_wait_state} !== 2'b00) begin
            n_bad++; $display("FAIL rst_in_wait_flags: got %b%b want 00", mem_timeout, mem_wait_state);
        end
        n_cmp++;
        if ({stall_cycles, flush_events, mem_wait_cycles} !== 96'd0) begin
            n_bad++; $display("FAIL rst_in_wait_cnts: got %0d/%0d/%0d want 0/0/0", stall_cycles, flush_events, mem_wait_cycles);
        end
        rst = 1'b0;
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (ctl !== E_RUN) begin n_bad++; $display("FAIL post_rst_ctl: got %b want %b", ctl, E_RUN); end
        tick();
        n_cmp++;
        if ({mem_timeout, stall_cycles} !== {1'b0, 32'd0}) begin
            n_bad++; $display("FAIL post_rst_state: got %b/%0d want 0/0", mem_timeout, stall_cycles);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_rd_zero();
        test_redirect_luh();
        test_mem_stall();
        test_redirect_during_stall();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Central hazard and sequencing controller for the RV32I 5-stage pipeline. It drives the enable and flush inputs of the PC register and of the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers. It resolves load-use hazards, taken branches and jumps, and data-memory wait states. It keeps performance counters and a memory-timeout flag.

## Interface
Parameters:
- MEM_TIMEOUT, 255, max consecutive MEM wait cycles before mem_timeout sets (1..65535)
- CNT_W, 32, width of each performance counter

Ports:
- clk  in  1  system clock, all state on posedge
- rst  in  1  synchronous, active-high reset
- rs1_id  in  5  rs1 index of instruction in ID
- rs2_id  in  5  rs2 index of instruction in ID
- rs1_used_id  in  1  ID instruction reads rs1
- rs2_used_id  in  1  ID instruction reads rs2
- rd_ex  in  5  destination of instruction in EX
- load_ex  in  1  instruction in EX is a load
- redirect_ex  in  1  EX resolved a taken branch, jal or jalr
- dmem_req_mem  in  1  instruction in MEM accesses data memory
- dmem_ready  in  1  data memory completes the access this cycle
- pc_en  out  1  PC register load enable
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage register enables
- if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  load a bubble (all control fields 0) on next edge
- stall_cycles, flush_events, mem_wait_cycles  out  CNT_W each  performance counters
- mem_timeout  out  1  sticky timeout flag
- mem_wait_state  out  1  1 while FSM is in WAIT

## Operation
- Hazard terms, combinational:
  - luh = load_ex && rd_ex != 0 && ((rs1_used_id && rs1_id == rd_ex) || (rs2_used_id && rs2_id == rd_ex))
  - mst = dmem_req_mem && !dmem_ready
- Priority, highest first:
  1. mst: pc_en, if_id_en, id_ex_en, ex_mem_en = 0. mem_wb_flush = 1. No other flush.
  2. redirect_ex: all enables = 1. if_id_flush = id_ex_flush = 1. PC loads the target. Any luh is ignored because it is wrong-path.
  3. luh: pc_en = if_id_en = 0. id_ex_en = 1 with id_ex_flush = 1. ex_mem_en = mem_wb_en = 1.
  4. Otherwise: all enables = 1, all flushes = 0.
- A redirect that arrives during mst stays held in frozen EX. It takes effect in the first cycle mst is low.
- FSM states:
  - RUN: go to WAIT when mst.
  - WAIT: go to RUN when !mst.
  - wait_cnt (16-bit) clears on entering WAIT, increments each WAIT cycle, and saturates.
  - mem_timeout sets when wait_cnt reaches MEM_TIMEOUT. It stays set until rst. The pipeline keeps stalling; there is no auto-abort.
- Counters wrap modulo 2^CNT_W:
  - stall_cycles increments each cycle pc_en = 0.
  - flush_events increments each cycle redirect is applied (priority 2).
  - mem_wait_cycles increments each cycle mst = 1.

## Timing
- All enable and flush outputs are combinational from current inputs. They take effect at the next posedge, so hazard-to-action latency is 0 cycles.
- Load-use costs exactly 1 bubble. The next cycle the load is in MEM and luh is 0 unless mst.
- A taken redirect costs exactly 2 bubbles (IF/ID and ID/EX).
- Counters, FSM state, wait_cnt and mem_timeout are registered and update on the edge after the qualifying cycle.
- Reset: state = RUN, wait_cnt = 0, all counters = 0, mem_timeout = 0, mem_wait_state = 0.
- While rst = 1, outputs are pc_en = 0, all stage enables = 1, and all flushes = 1, which flushes the pipeline to bubbles.
- Asserting rst in WAIT returns to RUN on the next edge and clears the counters.

## Structure
- Shared package pipeline_pkg: fsm state enum (RUN, WAIT), the bubble control-field constant, and the CNT_W default.
- One natural sub-module: hazard_detect (pure combinational luh and mst).
- The FSM, counters and priority mux live in pipeline_controller.

## Test plan
- Load-use: rd_ex = 5, load_ex = 1, rs1_id = 5, rs1_used_id = 1 -> pc_en = 0, if_id_en = 0, id_ex_flush = 1 for 1 cycle. stall_cycles = 1 afterwards.
- rd_ex = 0 with a load and matching rs1_id = 0 -> no stall, all enables 1.
- redirect_ex = 1 together with luh -> if_id_flush = id_ex_flush = 1, pc_en = 1. flush_events increments by 1, stall_cycles unchanged.
- dmem_ready low 3 cycles with dmem_req_mem = 1 -> pc_en through ex_mem_en = 0 and mem_wb_flush = 1 for 3 cycles. mem_wait_state = 1 for 3 cycles. mem_wait_cycles = 3.
- redirect_ex held during a 2-cycle mst -> no flush during the stall. Flushes assert in the cycle dmem_ready rises.
- MEM_TIMEOUT = 4, ready held low 10 cycles -> mem_timeout rises after the 4th WAIT cycle and stays 1 after ready. rst clears it, and clears state and counters to 0.
